// File: rtl/build_id_uart_tx.sv
// Transmits a 31-byte build-identification line ("H:<hash> T:<stamp>\r\n") as 8N1 UART.
// Define BUILD_ID_AUTOSEND_EN to send one message automatically after every reset release.
`timescale 1ns/1ps
module build_id_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic        clk100,
  input  logic        rstn,
  input  logic [63:0] git_hash_i,
  input  logic [31:0] timestamp_i,
  input  logic        start_i,
  output logic        tx_o,
  output logic        busy_o,
  output logic        done_o
);

  localparam int unsigned BaudW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
  localparam logic [4:0] LastByte = 5'd30;

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e            state_q;
  logic [BaudW-1:0]  baud_q;
  logic [2:0]        bit_q;
  logic [4:0]        byte_q;
  logic [63:0]       hash_q;
  logic [31:0]       ts_q;
  logic              tx_q;
  logic              busy_q;
  logic              done_q;

  logic [7:0]        cur_byte;
  logic [2:0]        bit_nxt;
  logic [3:0]        hash_nib;
  logic [2:0]        ts_nib;
  logic              baud_wrap;
  logic              go;

`ifdef BUILD_ID_AUTOSEND_EN
  logic auto_q;
  // High through reset, so the first released edge sees it once and then it clears.
  always_ff @(posedge clk100) begin
    auto_q <= ~rstn;
  end
  assign go = start_i | auto_q;
`else
  assign go = start_i;
`endif

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  assign baud_wrap = (baud_q == BaudLast);
  assign bit_nxt   = bit_q + 3'd1;

  // Byte 2 carries hash nibble 15 and byte 17 nibble 0; the modular difference maps directly.
  assign hash_nib = 4'd1 - byte_q[3:0];
  assign ts_nib   = 3'd4 - byte_q[2:0];

  always_comb begin
    cur_byte = 8'h0A;
    if (byte_q == 5'd0)       cur_byte = 8'h48;
    else if (byte_q == 5'd1)  cur_byte = 8'h3A;
    else if (byte_q <= 5'd17) cur_byte = hex_char(hash_q[{hash_nib, 2'b00} +: 4]);
    else if (byte_q == 5'd18) cur_byte = 8'h20;
    else if (byte_q == 5'd19) cur_byte = 8'h54;
    else if (byte_q == 5'd20) cur_byte = 8'h3A;
    else if (byte_q <= 5'd28) cur_byte = hex_char(ts_q[{ts_nib, 2'b00} +: 4]);
    else if (byte_q == 5'd29) cur_byte = 8'h0D;
  end

  always_ff @(posedge clk100) begin
    if (!rstn) begin
      state_q <= StIdle;
      baud_q  <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      hash_q  <= '0;
      ts_q    <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (go) begin
            state_q <= StStart;
            hash_q  <= git_hash_i;
            ts_q    <= timestamp_i;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
            baud_q  <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
          end
        end
        StStart: begin
          if (baud_wrap) begin
            baud_q  <= '0;
            bit_q   <= '0;
            tx_q    <= cur_byte[0];
            state_q <= StData;
          end else begin
            baud_q <= baud_q + BaudW'(1);
          end
        end
        StData: begin
          if (baud_wrap) begin
            baud_q <= '0;
            if (bit_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= StStop;
            end else begin
              bit_q <= bit_nxt;
              tx_q  <= cur_byte[bit_nxt];
            end
          end else begin
            baud_q <= baud_q + BaudW'(1);
          end
        end
        StStop: begin
          if (baud_wrap) begin
            baud_q <= '0;
            if (byte_q == LastByte) begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              byte_q  <= '0;
            end else begin
              byte_q  <= byte_q + 5'd1;
              tx_q    <= 1'b0;
              state_q <= StStart;
            end
          end else begin
            baud_q <= baud_q + BaudW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign tx_o   = tx_q;
  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule

// File: tb/tb_build_id_uart_tx.sv
// Directed self-checking bench for build_id_uart_tx at CLKS_PER_BIT=4.
`timescale 1ns/1ps
module tb_build_id_uart_tx;

  localparam int unsigned Cpb     = 4;
  localparam int          MsgCyc  = 310 * Cpb;
  localparam logic [63:0] Hash1   = 64'h0123456789ABCDEF;
  localparam logic [31:0] Ts1     = 32'h65A1B2C3;
  localparam logic [63:0] Hash2   = 64'hA5A50000FFFF1234;
  localparam logic [31:0] Ts2     = 32'h0000ABCD;

  logic        clk100;
  logic        rstn;
  logic [63:0] git_hash_i;
  logic [31:0] timestamp_i;
  logic        start_i;
  logic        tx_o;
  logic        busy_o;
  logic        done_o;

  int checks;
  int errors;

  string msg1;
  string msg2;

  build_id_uart_tx #(.CLKS_PER_BIT(Cpb)) u_dut (
    .clk100      (clk100),
    .rstn        (rstn),
    .git_hash_i  (git_hash_i),
    .timestamp_i (timestamp_i),
    .start_i     (start_i),
    .tx_o        (tx_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  initial clk100 = 1'b0;
  always #5 clk100 = ~clk100;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Call right after the accepting edge; samples every cycle of the message plus the done cycle.
  task automatic recv_msg(input string tag, input string exp, input bit clr_first,
                          input bit clr_end, input int poke_cyc);
    logic       tx_s [0:MsgCyc];
    int         busy_n;
    int         done_n;
    int         lvl_err;
    int         j;
    int         p;
    logic [7:0] ch;
    logic [7:0] b;
    logic       ebit;
    logic [9:0] hframe;
    busy_n  = 0;
    done_n  = 0;
    lvl_err = 0;
    for (int c = 0; c <= MsgCyc; c++) begin
      @(negedge clk100);
      tx_s[c] = tx_o;
      if (c < MsgCyc) begin
        busy_n += int'(busy_o);
        done_n += int'(done_o);
        j  = c / 40;
        p  = (c % 40) / 4;
        ch = exp[j];
        ebit = (p == 0) ? 1'b0 : (p == 9) ? 1'b1 : ch[p-1];
        if (tx_o !== ebit) lvl_err++;
      end else begin
        check({tag, "_done_pulse"}, {63'd0, done_o}, 64'd1);
        check({tag, "_done_busy"}, {63'd0, busy_o}, 64'd0);
        check({tag, "_done_tx"}, {63'd0, tx_o}, 64'd1);
      end
      if (c == 0 && clr_first) start_i = 1'b0;
      if (poke_cyc >= 0 && c == poke_cyc) begin
        git_hash_i = '1;
        start_i    = 1'b1;
      end
      if (poke_cyc >= 0 && c == poke_cyc + 1) start_i = 1'b0;
    end
    if (clr_end) start_i = 1'b0;
    check({tag, "_busy_cycles"}, 64'(busy_n), 64'(MsgCyc));
    check({tag, "_done_in_msg"}, 64'(done_n), 64'd0);
    check({tag, "_bit_levels"}, 64'(lvl_err), 64'd0);
    for (int i = 0; i < 10; i++) hframe[9-i] = tx_s[4*i];
    check({tag, "_first_frame"}, {54'd0, hframe}, {54'd0, 10'b0000100101});
    for (int k = 0; k < 31; k++) begin
      for (int n = 0; n < 8; n++) b[n] = tx_s[k*40 + 4*(n+1) + 2];
      ch = exp[k];
      check($sformatf("%s_byte%0d", tag, k), {56'd0, b}, {56'd0, ch});
    end
  endtask

  task automatic idle_check(input string tag, input int n);
    int busy_n;
    int low_n;
    int done_n;
    busy_n = 0;
    low_n  = 0;
    done_n = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk100);
      busy_n += int'(busy_o);
      low_n  += int'(!tx_o);
      done_n += int'(done_o);
    end
    check({tag, "_busy"}, 64'(busy_n), 64'd0);
    check({tag, "_tx_low"}, 64'(low_n), 64'd0);
    check({tag, "_done"}, 64'(done_n), 64'd0);
  endtask

  task automatic pulse_start();
    @(negedge clk100);
    start_i = 1'b1;
    @(posedge clk100);
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    msg1        = "H:0123456789ABCDEF T:65A1B2C3\r\n";
    msg2        = "H:A5A50000FFFF1234 T:0000ABCD\r\n";
    rstn        = 1'b0;
    start_i     = 1'b1;
    git_hash_i  = Hash1;
    timestamp_i = Ts1;

    // Reset with start_i high: must stay idle.
    repeat (3) @(posedge clk100);
    @(negedge clk100);
    check("rst_tx", {63'd0, tx_o}, 64'd1);
    check("rst_busy", {63'd0, busy_o}, 64'd0);
    check("rst_done", {63'd0, done_o}, 64'd0);
    start_i = 1'b0;
    rstn    = 1'b1;

`ifdef BUILD_ID_AUTOSEND_EN
    @(posedge clk100);
    recv_msg("auto", msg1, 1'b0, 1'b0, -1);
    idle_check("auto_after", 40);
`else
    idle_check("no_auto", 40);
`endif

    // Basic single-pulse message.
    pulse_start();
    recv_msg("msg1", msg1, 1'b1, 1'b0, -1);
    idle_check("msg1_after", 20);

    // Hash change plus ignored start at byte 10.
    pulse_start();
    recv_msg("freeze", msg1, 1'b1, 1'b0, 400);
    idle_check("freeze_after", 100);

    // Abort during byte 20, then a clean message with new inputs.
    git_hash_i  = Hash2;
    timestamp_i = Ts2;
    pulse_start();
    for (int c = 0; c <= 810; c++) begin
      @(negedge clk100);
      if (c == 0) start_i = 1'b0;
    end
    rstn = 1'b0;
    @(negedge clk100);
    check("abort_tx", {63'd0, tx_o}, 64'd1);
    check("abort_busy", {63'd0, busy_o}, 64'd0);
    check("abort_done", {63'd0, done_o}, 64'd0);
    rstn = 1'b1;
    idle_check("abort_after", 60);
    pulse_start();
    recv_msg("after_rst", msg2, 1'b1, 1'b0, -1);
    idle_check("after_rst_idle", 20);

    // start_i held high across two messages.
    git_hash_i  = Hash1;
    timestamp_i = Ts1;
    pulse_start();
    recv_msg("held1", msg1, 1'b0, 1'b0, -1);
    recv_msg("held2", msg1, 1'b0, 1'b1, -1);
    idle_check("held_after", 50);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
